uart_rx: RTL

UART receiver for the 8N1 serial link: 8 data bits LSB first, one start bit, one stop bit, no parity. It synchronises the asynchronous serial line, validates the start bit at mid-bit, and samples each data bit and the stop bit at bit centre. It presents each good byte with a one-cycle valid strobe and flags framing errors. It is the receive-side counterpart of `uart_tx` and shares its `CLKS_PER_BIT` convention and frame format.

---
 rtl/uart_rx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchroniser, mid-bit start validation,
// bit-centre sampling, one-cycle DV / framing-error strobes, break hold-off.
//
// Ports:
//   i_Clock        rising-edge clock
//   i_Rst_n        asynchronous active-low reset
//   i_Rx_Serial    asynchronous serial line, idles high
//   o_Rx_DV        one-cycle strobe, o_Rx_Byte holds a new good byte
//   o_Rx_Byte      last good byte, held between frames
//   o_Rx_Active    high from start-bit detection until frame end/abort
//   o_Rx_Frame_Err one-cycle strobe when the stop bit samples as 0
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_START   = 3'd1,
    s_DATA    = 3'd2,
    s_STOP    = 3'd3,
    s_CLEANUP = 3'd4,
    s_BREAK   = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       rx_m;
  logic       rx_s;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic       bit_end;
  logic       stop_hit;

  // Synchroniser resets to idle-high so reset release is not a start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_Rx_Serial;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= s_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      s_IDLE:
        if (!rx_s) state_nxt = s_START;
      s_START:
        if (cnt == HALF)
          state_nxt = rx_s ? s_IDLE : s_DATA;
      s_DATA:
        if (bit_end && idx == 3'd7)
          state_nxt = s_STOP;
      s_STOP:
        if (bit_end)
          state_nxt = rx_s ? s_CLEANUP : s_BREAK;
      s_CLEANUP:
        state_nxt = s_IDLE;
      s_BREAK:
        if (rx_s) state_nxt = s_IDLE;
      default:
        state_nxt = s_IDLE;
    endcase
  end

  always_comb begin
    bit_end     = (cnt == LAST);
    stop_hit    = (state == s_STOP) && bit_end;
    o_Rx_Active = (state != s_IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt   <= 8'd0;
      idx   <= 3'd0;
      shreg <= 8'd0;
    end else begin
      unique case (state)
        s_START:
          cnt <= (cnt == HALF) ? 8'd0 : cnt + 8'd1;
        s_DATA:
          if (bit_end) begin
            cnt        <= 8'd0;
            shreg[idx] <= rx_s;
            idx        <= idx + 3'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        s_STOP:
          cnt <= bit_end ? 8'd0 : cnt + 8'd1;
        default: begin
          cnt <= 8'd0;
          idx <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Byte      <= 8'd0;
    end else begin
      o_Rx_DV        <= stop_hit && rx_s;
      o_Rx_Frame_Err <= stop_hit && !rx_s;
      if (stop_hit && rx_s) o_Rx_Byte <= shreg;
    end
  end

endmodule
